pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces our fixed free-running stage registers (EX/MEM, MEM/WB and similar) by carrying an opaque packed payload of any width. It adds stall back-pressure without a combinational ready path, plus bubble insertion on flush. Instantiated once per stage boundary in the pipelined core.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_sat_counter.sv | 21 ++
 rtl/pipe_stage_skid.sv | 135 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline stage boundaries.
// Stage state encoding plus the packed payload layouts carried by
// pipe_stage_skid at each boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit event counter that sticks at all-ones.
// Cleared only by the asynchronous active-low reset.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a one-entry skid
// buffer and synchronous flush. in_ready is a pure state decode, so there
// is no combinational path from out_ready back upstream.
// Optional: PIPE_STAGE_STATS_EN adds saturating stall/bubble counters.
//
//   state | meaning
//   EMPTY | no beat held
//   FULL  | main register holds a beat
//   SKID  | main and skid registers both hold beats, in_ready low
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              issue;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    // Valid bits are implied by the state: main valid outside EMPTY,
    // skid valid only in SKID.
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    // Next state and register load enables; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept && issue) begin
                    load_main = 1'b1;
                end else if (issue) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = SKID;
                end
            end
            SKID: begin
                if (issue) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flushed beats are dropped by clearing validity; data just holds.
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (out_valid & ~out_ready),
        .count  (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (~out_valid),
        .count  (bubble_cnt)
    );
`else
    // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table, async reset and stats
// sequences, then a random stream, all checked against a FIFO model.
// Build with PIPE_STAGE_STATS_EN to include the counter checks.
module tb_pipe_stage_skid;

    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]    stall_cnt;
    logic [3:0]    bubble_cnt;
`endif

    int            total = 0;
    int            bad   = 0;
    int            m_stall  = 0;
    int            m_bubble = 0;
    logic [DW-1:0] mq[$];

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    vec_t vt[17];

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (DW)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the FIFO model at the edge, then compare 1 time unit later.
    task automatic step();
        bit acc;
        bit iss;
        acc = in_valid && (mq.size() < 2);
        iss = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            if (mq.size() > 0 && !out_ready && m_stall < 15) m_stall++;
            if (mq.size() == 0 && m_bubble < 15) m_bubble++;
            if (flush) begin
                mq.delete();
            end else begin
                if (iss) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
        end
        #1;
        check("model_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        check("model_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) check("model_out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_STATS_EN
        check("model_stall_cnt", {28'd0, stall_cnt}, m_stall);
        check("model_bubble_cnt", {28'd0, bubble_cnt}, m_bubble);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        //        iv  data      ordy fl  e_ov e_od      e_ir
        vt[0]  = '{1, 32'h11, 1, 0, 1, 32'h11, 1};
        vt[1]  = '{1, 32'h22, 1, 0, 1, 32'h22, 1};
        vt[2]  = '{1, 32'h33, 1, 0, 1, 32'h33, 1};
        vt[3]  = '{0, 32'h00, 1, 0, 0, 32'h00, 1};
        vt[4]  = '{1, 32'hA1, 1, 0, 1, 32'hA1, 1};
        vt[5]  = '{1, 32'hA2, 0, 0, 1, 32'hA1, 0};
        vt[6]  = '{1, 32'hA3, 0, 0, 1, 32'hA1, 0};
        vt[7]  = '{1, 32'hA3, 1, 0, 1, 32'hA2, 1};
        vt[8]  = '{1, 32'hA3, 1, 0, 1, 32'hA3, 1};
        vt[9]  = '{0, 32'h00, 1, 0, 0, 32'h00, 1};
        vt[10] = '{1, 32'hB1, 0, 0, 1, 32'hB1, 1};
        vt[11] = '{1, 32'hB2, 0, 0, 1, 32'hB1, 0};
        vt[12] = '{1, 32'hB3, 0, 1, 0, 32'h00, 1};
        vt[13] = '{0, 32'h00, 1, 0, 0, 32'h00, 1};
        vt[14] = '{1, 32'hC1, 1, 0, 1, 32'hC1, 1};
        vt[15] = '{1, 32'hC2, 0, 1, 0, 32'h00, 1};
        vt[16] = '{0, 32'h00, 1, 0, 0, 32'h00, 1};

        // Reset state.
        out_ready = 1'b1;
        step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        do_reset();

        // Directed vectors.
        for (int i = 0; i < 17; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].id;
            out_ready = vt[i].ordy;
            flush     = vt[i].fl;
            step();
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ov});
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_ir});
            if (vt[i].e_ov) check($sformatf("vec%0d_out_data", i), out_data, vt[i].e_od);
        end
        flush = 1'b0;

        // Asynchronous reset while FULL clears outputs without a clock edge.
        in_valid  = 1'b1;
        in_data   = 32'hD1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_out_data", out_data, 32'hD1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", out_data, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        in_valid  = 1'b1;
        in_data   = 32'hE1;
        out_ready = 1'b1;
        step();
        step();
        check("rst_held_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        step();

`ifdef PIPE_STAGE_STATS_EN
        // Saturating stall counter; bubbles stop counting while stalled.
        do_reset();
        out_ready = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 32'hF1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("stats_stall_sat", {28'd0, stall_cnt}, 32'd15);
        check("stats_bubble_held", {28'd0, bubble_cnt}, 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stats_stall_after_flush", {28'd0, stall_cnt}, 32'd15);
`endif

        // Random stream against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
